// File: rtl/mem_master_pkg.sv
// Shared types and constants for the mem_master memory initiator.
package mem_master_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  // Command / response operation encoding.
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Controller states; VRD and VCMP are only reachable in the verify build.
  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP,
    VRD,
    VCMP
  } state_t;

endpackage : mem_master_pkg

// File: rtl/mem_master.sv
// mem_master: single-outstanding command initiator for the 16x32 synchronous
// single-port memory. Drives the memory pins from registers, captures the
// registered Data_out for reads, and returns a response on a valid/ready channel.
// Optional feature: define MEM_MASTER_VERIFY_EN to follow every write with a
// readback and report a data mismatch on rsp_err.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              Clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_t state;
  logic   op_q;   // operation of the command in flight

`ifndef MEM_MASTER_VERIFY_EN
  // Without readback there is nothing to compare, so no error can be reported.
  assign rsp_err = 1'b0;
`endif

  // Controller FSM with all outputs registered.
  // NOTE: every state/output register uses <= so all updates take effect
  // together at the edge, independent of statement order.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      op_q         <= OP_READ;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_write    <= 1'b0;
      rsp_rdata    <= '0;
`ifdef MEM_MASTER_VERIFY_EN
      rsp_err      <= 1'b0;
`endif
      mem_data_in  <= '0;
      mem_address  <= '0;
      mem_write_en <= 1'b0;
      mem_read_en  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            mem_address  <= cmd_addr;
            mem_data_in  <= cmd_wdata;
            op_q         <= cmd_write;
            cmd_ready    <= 1'b0;
            mem_write_en <= (cmd_write == OP_WRITE);
            mem_read_en  <= (cmd_write == OP_READ);
            state        <= ACCESS;
          end
        end

        ACCESS: begin
          mem_write_en <= 1'b0;
          if (op_q == OP_WRITE) begin
`ifdef MEM_MASTER_VERIFY_EN
            // Read the just-written word back from the same address.
            mem_read_en <= 1'b1;
            state       <= VRD;
`else
            mem_read_en <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_write   <= OP_WRITE;
            rsp_rdata   <= '0;
            state       <= RESP;
`endif
          end else begin
            mem_read_en <= 1'b0;
            state       <= CAPTURE;
          end
        end

        CAPTURE: begin
          rsp_valid <= 1'b1;
          rsp_write <= OP_READ;
          rsp_rdata <= mem_data_out;
`ifdef MEM_MASTER_VERIFY_EN
          rsp_err   <= 1'b0;
`endif
          state     <= RESP;
        end

`ifdef MEM_MASTER_VERIFY_EN
        VRD: begin
          mem_read_en <= 1'b0;
          state       <= VCMP;
        end

        VCMP: begin
          // mem_data_in still holds the write data of this command.
          rsp_valid <= 1'b1;
          rsp_write <= OP_WRITE;
          rsp_rdata <= mem_data_out;
          rsp_err   <= (mem_data_out != mem_data_in);
          state     <= RESP;
        end
`endif

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : mem_master
